axi_sram_slave: RTL and testbench

AXI slave responder with on-chip word-addressed SRAM. It is the memory end of the bus driven by cpu_axi_interface and serves as a synthesizable, behaviourally defined stand-in for ram_axi4 in core-level simulation. It has independent read and write engines, each with one outstanding transaction, and supports FIXED, INCR and WRAP bursts with byte strobes.

---
 rtl/axi_sram_slave_if.sv | 66 ++++++
 rtl/axi_sram_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI bus bundle between a master and the axi_sram_slave memory responder.
// The master modport drives requests; the slave modport drives ready and response channels.
interface axi_sram_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI slave backed by a word-addressed on-chip SRAM; independent read and write
// engines, one outstanding transaction each, FIXED/INCR/WRAP bursts with byte strobes.
module axi_sram_slave #(
  parameter int DEPTH_LOG2 = 12,
  parameter int ID_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi_sram_slave_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t        w_state;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr;
  logic [7:0]      w_len;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic [7:0]      w_cnt;
  logic            w_err;

  r_state_t        r_state;
  logic [31:0]     r_addr;
  logic [7:0]      r_len;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic [7:0]      r_cnt;

  function automatic logic [2:0] eff_size(input logic [2:0] size);
    return (size > 3'd2) ? 3'd2 : size;
  endfunction

  // Oversized beats, the reserved burst code and illegal WRAP lengths answer SLVERR.
  function automatic logic cfg_err(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'd2) || (burst == 2'b11) || bad_wrap;
  endfunction

  // The reserved burst code advances like INCR so its data path still runs.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] bnd;
    step = 32'd1 << eff_size(size);
    bnd  = step * ({24'd0, len} + 32'd1);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~(bnd - 32'd1)) | ((addr + step) & (bnd - 32'd1));
      default: return addr + step;
    endcase
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
    return addr[DEPTH_LOG2+1:2];
  endfunction

  logic w_fire;
  logic w_final;
  logic w_last_bad;
  assign w_fire     = (w_state == W_DATA) && bus.wvalid && bus.wready;
  assign w_final    = (w_cnt == w_len);
  assign w_last_bad = (bus.wlast != w_final);

  // NOTE: the SRAM array carries no reset; contents survive rst and only the control state clears.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // NOTE: state and every registered output use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      w_id        <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_size      <= '0;
      w_burst     <= '0;
      w_cnt       <= '0;
      w_err       <= 1'b0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bid     <= '0;
      bus.bresp   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          bus.awready <= 1'b1;
          if (bus.awvalid && bus.awready) begin
            w_id        <= bus.awid;
            w_addr      <= bus.awaddr;
            w_len       <= bus.awlen;
            w_size      <= bus.awsize;
            w_burst     <= bus.awburst;
            w_cnt       <= '0;
            w_err       <= cfg_err(bus.awsize, bus.awlen, bus.awburst);
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_err  <= w_err | w_last_bad;
            if (w_final) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bid    <= w_id;
              bus.bresp  <= (w_err || w_last_bad) ? 2'b10 : 2'b00;
              w_state    <= W_RESP;
            end
          end
        end
        default: begin
          if (bus.bready) begin
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
      endcase
    end
  end

  // The next beat's word is fetched on the accepting edge, so rready held high streams without bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rid     <= '0;
      bus.rdata   <= '0;
      bus.rresp   <= '0;
      bus.rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          bus.arready <= 1'b1;
          if (bus.arvalid && bus.arready) begin
            r_addr      <= bus.araddr;
            r_len       <= bus.arlen;
            r_size      <= bus.arsize;
            r_burst     <= bus.arburst;
            r_cnt       <= '0;
            bus.rid     <= bus.arid;
            bus.rdata   <= mem[word_idx(bus.araddr)];
            bus.rresp   <= cfg_err(bus.arsize, bus.arlen, bus.arburst) ? 2'b10 : 2'b00;
            bus.rlast   <= (bus.arlen == 8'd0);
            bus.rvalid  <= 1'b1;
            bus.arready <= 1'b0;
            r_state     <= R_DATA;
          end
        end
        default: begin
          if (bus.rready) begin
            if (bus.rlast) begin
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_addr    <= next_addr(r_addr, r_size, r_len, r_burst);
              bus.rdata <= mem[word_idx(next_addr(r_addr, r_size, r_len, r_burst))];
              r_cnt     <= r_cnt + 8'd1;
              bus.rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised self-checking bench for axi_sram_slave against a word-array memory model
// whose beat addresses come from closed-form burst arithmetic.
module tb_axi_sram_slave;
  localparam int ID_W       = 4;
  localparam int DEPTH_LOG2 = 12;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int TMO        = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.ID_W(ID_W)) bus ();

  axi_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Byte address of beat n of a burst, from the burst definition directly.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                            input int len, input int burst, input int n);
    int unsigned step;
    int unsigned bnd;
    int unsigned base;
    step = 1 << ((size > 2) ? 2 : size);
    if (burst == 0) return start;
    if (burst == 2) begin
      bnd  = step * (len + 1);
      base = (start / bnd) * bnd;
      return base + ((start - base) + n * step) % bnd;
    end
    return start + n * step;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input logic [31:0] data[$],
                           input logic [3:0] strb[$], input int early_last, input int b_hold,
                           input logic [1:0] exp_resp);
    int n;
    logic [31:0] w;
    logic [3:0]  hid;
    logic [1:0]  hresp;
    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = 3'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    check("aw_ready_timeout", bus.awready, 1'b1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1;
      bus.wid    = 4'($urandom);
      bus.wdata  = data[i];
      bus.wstrb  = strb[i];
      bus.wlast  = (early_last >= 0) ? (i == early_last) : (i == len);
      n = 0;
      while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
      if (!bus.wready) check("w_ready_timeout", bus.wready, 1'b1);
      w = ref_mem.exists(widx(beat_addr(addr, size, len, burst, i))) ?
          ref_mem[widx(beat_addr(addr, size, len, burst, i))] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[i][b]) w[8*b +: 8] = data[i][8*b +: 8];
      ref_mem[widx(beat_addr(addr, size, len, burst, i))] = w;
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    check("b_valid_timeout", bus.bvalid, 1'b1);
    hid = bus.bid; hresp = bus.bresp;
    for (int k = 0; k < b_hold; k++) begin
      @(negedge clk);
      check("b_hold_valid", bus.bvalid, 1'b1);
      check("b_hold_id", bus.bid, hid);
      check("b_hold_resp", bus.bresp, hresp);
      check("aw_blocked", bus.awready, 1'b0);
    end
    check("bid", bus.bid, id);
    check("bresp", bus.bresp, exp_resp);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_drop", bus.bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input logic [1:0] exp_resp,
                          input int stall_beat, input int stall_cycles);
    int n;
    logic [31:0] hdata;
    logic        hlast;
    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = 3'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
    bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
    check("ar_ready_timeout", bus.arready, 1'b1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("r_first_latency", bus.rvalid, 1'b1);
    for (int i = 0; i <= len; i++) begin
      if (i == stall_beat) begin
        bus.rready = 1'b0;
        hdata = bus.rdata; hlast = bus.rlast;
        for (int k = 0; k < stall_cycles; k++) begin
          @(negedge clk);
          check("r_hold_valid", bus.rvalid, 1'b1);
          check("r_hold_data", bus.rdata, hdata);
          check("r_hold_last", bus.rlast, hlast);
        end
        bus.rready = 1'b1;
      end
      check("r_valid_streaming", bus.rvalid, 1'b1);
      check("rdata", bus.rdata, ref_mem[widx(beat_addr(addr, size, len, burst, i))]);
      check("rlast", bus.rlast, (i == len));
      check("rid", bus.rid, id);
      check("rresp", bus.rresp, exp_resp);
      @(negedge clk);
    end
    bus.rready = 1'b0;
    check("r_drop", bus.rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    int n;
    int burst, size, len, step;
    logic [31:0] start;

    rst = 1'b1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rlast", bus.rlast, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", bus.awready, 1'b1);
    check("post_rst_arready", bus.arready, 1'b1);

    // Single beat write and read back.
    dq = '{32'hDEADBEEF}; sq = '{4'hF};
    axi_write(4'd3, 32'h10, 0, 2, 1, dq, sq, -1, 0, 2'b00);
    axi_read(4'd5, 32'h10, 0, 2, 1, 2'b00, -1, 0);

    // Four-beat INCR streaming read.
    dq = '{32'd1, 32'd2, 32'd3, 32'd4}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'd1, 32'h100, 3, 2, 1, dq, sq, -1, 0, 2'b00);
    axi_read(4'd2, 32'h100, 3, 2, 1, 2'b00, -1, 0);

    // Byte strobes merge into an existing word.
    dq = '{32'h11223344}; sq = '{4'hF};
    axi_write(4'd4, 32'h20, 0, 2, 1, dq, sq, -1, 0, 2'b00);
    dq = '{32'hAABBCCDD}; sq = '{4'b0101};
    axi_write(4'd4, 32'h20, 0, 2, 1, dq, sq, -1, 0, 2'b00);
    check("strobe_merge_model", ref_mem[widx(32'h20)], 32'h11BB33DD);
    axi_read(4'd6, 32'h20, 0, 2, 1, 2'b00, -1, 0);

    // WRAP read over word-index data.
    dq = '{32'hC, 32'hD, 32'hE, 32'hF}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'd7, 32'h30, 3, 2, 1, dq, sq, -1, 0, 2'b00);
    axi_read(4'd8, 32'h38, 3, 2, 2, 2'b00, -1, 0);

    // Back-pressure on B and R.
    dq = '{32'h5A5A0001, 32'h5A5A0002}; sq = '{4'hF, 4'hF};
    axi_write(4'd9, 32'h200, 1, 2, 1, dq, sq, -1, 5, 2'b00);
    axi_read(4'd10, 32'h100, 3, 2, 1, 2'b00, 2, 3);

    // Early wlast, reserved burst code, INCR crossing the top of memory.
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'd11, 32'h300, 3, 2, 1, dq, sq, 1, 0, 2'b10);
    dq = '{32'hBADC0DE5}; sq = '{4'hF};
    axi_write(4'd12, 32'h40, 0, 2, 3, dq, sq, -1, 0, 2'b10);
    axi_read(4'd12, 32'h40, 0, 2, 3, 2'b10, -1, 0);
    dq = '{32'h7777AAAA, 32'h8888BBBB}; sq = '{4'hF, 4'hF};
    axi_write(4'd13, 32'h3FFC, 1, 2, 1, dq, sq, -1, 0, 2'b00);
    axi_read(4'd13, 32'h0, 0, 2, 1, 2'b00, -1, 0);
    axi_read(4'd14, 32'h3FFC, 1, 2, 1, 2'b00, -1, 0);

    // 256-beat fill of 0x400..0x7FF.
    dq.delete(); sq.delete();
    for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_write(4'd15, 32'h400, 255, 2, 1, dq, sq, -1, 0, 2'b00);
    axi_read(4'd0, 32'h400, 255, 2, 1, 2'b00, -1, 0);

    // Reset in the middle of a read burst.
    @(negedge clk);
    bus.arid = 4'd3; bus.araddr = 32'h400; bus.arlen = 8'd7;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
    check("mid_rst_ar_timeout", bus.arready, 1'b1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 1'b0);
    check("mid_rst_rlast", bus.rlast, 1'b0);
    check("mid_rst_arready", bus.arready, 1'b0);
    @(negedge clk);
    rst = 1'b0; bus.rready = 1'b0;
    n = 0;
    while (!bus.arready && n < 4) begin @(negedge clk); n++; end
    check("mid_rst_arready_back", bus.arready, 1'b1);
    check("mid_rst_no_rvalid", bus.rvalid, 1'b0);
    axi_read(4'd1, 32'h100, 3, 2, 1, 2'b00, -1, 0);
    axi_read(4'd2, 32'h400, 7, 2, 1, 2'b00, -1, 0);

    // Random bursts inside the filled region.
    for (int t = 0; t < 30; t++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      step  = 1 << size;
      if (burst == 2) begin
        n   = $urandom_range(0, 3);
        len = (2 << n) - 1;
      end else begin
        len = $urandom_range(0, 15);
      end
      start = 32'h400 + ((32'($urandom_range(0, 32'h380))) & ~(32'(step) - 32'd1));
      dq.delete(); sq.delete();
      for (int i = 0; i <= len; i++) begin
        dq.push_back($urandom);
        sq.push_back(4'($urandom));
      end
      axi_write(4'($urandom), start, len, size, burst, dq, sq, -1,
                $urandom_range(0, 2), 2'b00);
      axi_read(4'($urandom), start, len, size, burst, 2'b00,
               $urandom_range(0, len + 3), $urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
